// File: rtl/cpu_defines.sv
// Shared CPU types: word/register types, memory-op encoding, byte-enable constants
// and the lane helpers used by the memory stage.
package cpu_defines;
  typedef logic [31:0] Word_t;
  typedef logic [4:0]  Reg_addr_t;

  localparam Reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [3:0] {MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW} Mem_op_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load(input Mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic is_store(input Mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  // Little-endian lanes; halfword lane chosen by off[1] so off[0] is ignored.
  function automatic logic [3:0] byte_en(input Mem_op_t op, input logic [1:0] off);
    case (op)
      LB, LBU, SB: byte_en = BE_BYTE << off;
      LH, LHU, SH: byte_en = off[1] ? BE_HALF_HI : BE_HALF_LO;
      LW, SW:      byte_en = BE_WORD;
      default:     byte_en = BE_NONE;
    endcase
  endfunction

  function automatic Word_t store_data(input Mem_op_t op, input Word_t d);
    case (op)
      SB:      store_data = {4{d[7:0]}};
      SH:      store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic misaligned(input Mem_op_t op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: misaligned = off[0];
      LW, SW:      misaligned = |off;
      default:     misaligned = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select: picks the addressed byte/halfword of the bus word and extends it.
module load_align
  import cpu_defines::*;
(
  input  Mem_op_t    op,
  input  logic [1:0] off,
  input  Word_t      rdata,
  output Word_t      data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      LB:      data = {{24{lane_b[7]}}, lane_b};
      LBU:     data = {24'b0, lane_b};
      LH:      data = {{16{lane_h[15]}}, lane_h};
      LHU:     data = {16'b0, lane_h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// MEM stage: ALU results pass straight to WB; loads/stores run one bus transaction
// and stall upstream until acked. MEM_ALIGN_CHECK_EN enables misaligned-address traps.
module mem_access
  import cpu_defines::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      mem_wreg_write,
  input  Reg_addr_t mem_wreg_addr,
  input  Word_t     mem_wreg_data,
  input  logic      mem_whilo,
  input  Word_t     mem_hi,
  input  Word_t     mem_lo,
  input  Mem_op_t   mem_op,
  input  Word_t     mem_addr,
  input  Word_t     mem_sdata,
  output logic      bus_req,
  output logic      bus_we,
  output Word_t     bus_addr,
  output logic [3:0] bus_be,
  output Word_t     bus_wdata,
  input  Word_t     bus_rdata,
  input  logic      bus_ack,
  output logic      wb_wreg_write,
  output Reg_addr_t wb_wreg_addr,
  output Word_t     wb_wreg_data,
  output logic      wb_whilo,
  output Word_t     wb_hi,
  output Word_t     wb_lo,
  output logic      stall_req,
  output logic      exc_addr_err,
  output Word_t     exc_badvaddr
);
  typedef enum logic {IDLE, BUS} state_t;

  state_t state;
  logic   is_mem, misalign;
  Word_t  ld_data, wb_data_next;

  assign is_mem = (mem_op != MEM_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = misaligned(mem_op, mem_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // A trapped access never reaches the bus, so it must not stall either.
  assign stall_req = (state == IDLE) ? (is_mem && !misalign) : !bus_ack;

  load_align u_load_align (
    .op    (mem_op),
    .off   (mem_addr[1:0]),
    .rdata (bus_rdata),
    .data  (ld_data)
  );

  assign wb_data_next = is_load(mem_op) ? ld_data : mem_wreg_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= BE_NONE;
      bus_wdata     <= '0;
      wb_wreg_write <= 1'b0;
      wb_wreg_addr  <= REG_ZERO;
      wb_wreg_data  <= '0;
      wb_whilo      <= 1'b0;
      wb_hi         <= '0;
      wb_lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_wreg_write <= mem_wreg_write;
            wb_wreg_addr  <= mem_wreg_addr;
            wb_wreg_data  <= mem_wreg_data;
            wb_whilo      <= mem_whilo;
            wb_hi         <= mem_hi;
            wb_lo         <= mem_lo;
          end else if (misalign) begin
            wb_wreg_write <= 1'b0;
            wb_whilo      <= 1'b0;
          end else begin
            state         <= BUS;
            bus_req       <= 1'b1;
            bus_we        <= is_store(mem_op);
            bus_addr      <= {mem_addr[31:2], 2'b00};
            bus_be        <= byte_en(mem_op, mem_addr[1:0]);
            bus_wdata     <= store_data(mem_op, mem_sdata);
            wb_wreg_write <= 1'b0;
            wb_whilo      <= 1'b0;
          end
        end
        BUS: begin
          // mem_* are held by the stall, so they still describe this access here.
          if (bus_ack) begin
            state         <= IDLE;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            wb_wreg_write <= mem_wreg_write;
            wb_wreg_addr  <= mem_wreg_addr;
            wb_wreg_data  <= wb_data_next;
            wb_whilo      <= mem_whilo;
            wb_hi         <= mem_hi;
            wb_lo         <= mem_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_addr_err <= 1'b0;
      exc_badvaddr <= '0;
    end else begin
      exc_addr_err <= (state == IDLE) && is_mem && misalign;
      if ((state == IDLE) && is_mem && misalign) exc_badvaddr <= mem_addr;
    end
  end
`else
  assign exc_addr_err = 1'b0;
  assign exc_badvaddr = '0;
`endif
endmodule

// File: tb/tb_mem_access.sv
// Scoreboarded bench for mem_access: expected WB results queued at issue, popped at completion.
module tb_mem_access;
  import cpu_defines::*;

  logic clk, rst;
  logic mem_wreg_write, mem_whilo, bus_ack;
  Reg_addr_t mem_wreg_addr;
  Word_t mem_wreg_data, mem_hi, mem_lo, mem_addr, mem_sdata, bus_rdata;
  Mem_op_t mem_op;
  logic bus_req, bus_we, wb_wreg_write, wb_whilo, stall_req, exc_addr_err;
  logic [3:0] bus_be;
  Word_t bus_addr, bus_wdata, wb_wreg_data, wb_hi, wb_lo, exc_badvaddr;
  Reg_addr_t wb_wreg_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic wr; Reg_addr_t addr; Word_t data; logic whilo; Word_t hi; Word_t lo;
  } wb_exp_t;
  wb_exp_t sb_q[$];

  // values seen on the first BUS cycle of the last access
  logic cap_req, cap_we, cap_wbw;
  logic [3:0] cap_be;
  Word_t cap_addr, cap_wdata;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_wreg_write(mem_wreg_write), .mem_wreg_addr(mem_wreg_addr), .mem_wreg_data(mem_wreg_data),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_wreg_write(wb_wreg_write), .wb_wreg_addr(wb_wreg_addr), .wb_wreg_data(wb_wreg_data),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .stall_req(stall_req), .exc_addr_err(exc_addr_err), .exc_badvaddr(exc_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    mem_op = MEM_NONE; mem_wreg_write = 1'b0; mem_wreg_addr = REG_ZERO; mem_wreg_data = '0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0; mem_addr = '0; mem_sdata = '0; bus_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Runs the access already driven on mem_*; ack rises after wait_n BUS cycles.
  // Returns at 1 time unit past the completion edge, inputs back to idle.
  task automatic run_access(input int wait_n, output int stalls, output bit done);
    stalls = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_ack = (c >= 1 + wait_n);
      @(negedge clk);
      if (c == 1) begin
        cap_req = bus_req; cap_we = bus_we; cap_addr = bus_addr;
        cap_be = bus_be; cap_wdata = bus_wdata; cap_wbw = wb_wreg_write;
      end
      if (stall_req) stalls++; else done = 1'b1;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); bus_rdata = '0; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus_req, bus_we, bus_be} !== 6'b0) begin failures++; $display("FAIL reset_bus_ctl got=%b exp=0", {bus_req, bus_we, bus_be}); end
    checks++; if ({bus_addr, bus_wdata} !== 64'h0) begin failures++; $display("FAIL reset_bus_data got=%h exp=0", {bus_addr, bus_wdata}); end
    checks++; if ({wb_wreg_write, wb_wreg_addr, wb_wreg_data, wb_whilo, wb_hi, wb_lo} !== '0) begin failures++; $display("FAIL reset_wb got=%h exp=0", {wb_wreg_write, wb_wreg_addr, wb_wreg_data, wb_whilo, wb_hi, wb_lo}); end
    checks++; if ({exc_addr_err, exc_badvaddr, stall_req} !== '0) begin failures++; $display("FAIL reset_exc got=%h exp=0", {exc_addr_err, exc_badvaddr, stall_req}); end
    next_cycle(); rst = 1'b1; next_cycle();
  endtask

  task automatic test_alu_pass();
    wb_exp_t e;
    for (int i = 0; i < 3; i++) begin
      mem_op = MEM_NONE; mem_wreg_write = (i != 1); mem_wreg_addr = (i == 0) ? 5'd5 : 5'(20 + i);
      mem_wreg_data = (i == 0) ? 32'h1234 : 32'hA5A5_0000 + i; mem_whilo = (i == 2);
      mem_hi = 32'h0123_4567 + i; mem_lo = 32'h89AB_CDEF - i;
      sb_q.push_back('{mem_wreg_write, mem_wreg_addr, mem_wreg_data, mem_whilo, mem_hi, mem_lo});
      @(negedge clk);
      checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL alu_stall[%0d] got=%b exp=0", i, stall_req); end
      next_cycle();
      e = sb_q.pop_front();
      checks++; if ({wb_wreg_write, wb_wreg_addr, wb_wreg_data} !== {e.wr, e.addr, e.data}) begin failures++; $display("FAIL alu_wreg[%0d] got=%h exp=%h", i, {wb_wreg_write, wb_wreg_addr, wb_wreg_data}, {e.wr, e.addr, e.data}); end
      checks++; if ({wb_whilo, wb_hi, wb_lo} !== {e.whilo, e.hi, e.lo}) begin failures++; $display("FAIL alu_hilo[%0d] got=%h exp=%h", i, {wb_whilo, wb_hi, wb_lo}, {e.whilo, e.hi, e.lo}); end
    end
    idle_inputs();
  endtask

  task automatic test_loads();
    Mem_op_t    ops   [6] = '{LB, LBU, LH, LHU, LB, LW};
    Word_t      addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h104};
    Word_t      rd    [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80010000, 32'h1234F00D, 32'h00007F00, 32'hCAFEF00D};
    Word_t      exp_d [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F, 32'hCAFEF00D};
    logic [3:0] exp_be[6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
    Word_t      exp_a [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
    int         waits [6] = '{3, 3, 1, 2, 0, 0};
    int stalls; bit done; wb_exp_t e;
    for (int i = 0; i < 6; i++) begin
      mem_op = ops[i]; mem_addr = addrs[i]; bus_rdata = rd[i];
      mem_wreg_write = 1'b1; mem_wreg_addr = 5'(10 + i); mem_wreg_data = 32'h5555_5555;
      mem_whilo = 1'b1; mem_hi = 32'h1000 + i; mem_lo = 32'h2000 + i;
      sb_q.push_back('{1'b1, 5'(10 + i), exp_d[i], 1'b1, 32'h1000 + i, 32'h2000 + i});
      run_access(waits[i], stalls, done);
      checks++; if (!done || stalls != waits[i] + 1) begin failures++; $display("FAIL load_stall[%0d] got=%0d done=%0d exp=%0d", i, stalls, done, waits[i] + 1); end
      checks++; if ({cap_req, cap_we, cap_wbw} !== 3'b100) begin failures++; $display("FAIL load_ctl[%0d] got=%b exp=100", i, {cap_req, cap_we, cap_wbw}); end
      checks++; if (cap_be !== exp_be[i] || cap_addr !== exp_a[i]) begin failures++; $display("FAIL load_be_addr[%0d] got=%b/%h exp=%b/%h", i, cap_be, cap_addr, exp_be[i], exp_a[i]); end
      e = sb_q.pop_front();
      checks++; if ({wb_wreg_write, wb_wreg_addr, wb_wreg_data} !== {e.wr, e.addr, e.data}) begin failures++; $display("FAIL load_wb[%0d] got=%h exp=%h", i, {wb_wreg_write, wb_wreg_addr, wb_wreg_data}, {e.wr, e.addr, e.data}); end
      checks++; if ({wb_whilo, wb_hi, wb_lo, bus_req} !== {e.whilo, e.hi, e.lo, 1'b0}) begin failures++; $display("FAIL load_hilo_req[%0d] got=%h exp=%h", i, {wb_whilo, wb_hi, wb_lo, bus_req}, {e.whilo, e.hi, e.lo, 1'b0}); end
    end
  endtask

  task automatic test_stores();
    Mem_op_t    ops   [4] = '{SH, SB, SW, SH};
    Word_t      addrs [4] = '{32'h202, 32'h301, 32'h404, 32'h500};
    Word_t      sd    [4] = '{32'hAAAABEEF, 32'h1234565A, 32'hDEADBEEF, 32'h00001357};
    Word_t      exp_w [4] = '{32'hBEEFBEEF, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h13571357};
    logic [3:0] exp_be[4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
    Word_t      exp_a [4] = '{32'h200, 32'h300, 32'h404, 32'h500};
    int stalls; bit done; wb_exp_t e;
    for (int i = 0; i < 4; i++) begin
      mem_op = ops[i]; mem_addr = addrs[i]; mem_sdata = sd[i]; bus_rdata = 32'hFFFF_FFFF;
      mem_wreg_write = i[0]; mem_wreg_addr = 5'(3 + i); mem_wreg_data = 32'h0BAD_0000 + i;
      mem_whilo = ~i[0]; mem_hi = 32'h7000 + i; mem_lo = 32'h8000 + i;
      sb_q.push_back('{i[0], 5'(3 + i), 32'h0BAD_0000 + i, ~i[0], 32'h7000 + i, 32'h8000 + i});
      run_access(i, stalls, done);
      checks++; if (!done || stalls != i + 1) begin failures++; $display("FAIL store_stall[%0d] got=%0d done=%0d exp=%0d", i, stalls, done, i + 1); end
      checks++; if ({cap_req, cap_we, cap_be} !== {2'b11, exp_be[i]}) begin failures++; $display("FAIL store_ctl_be[%0d] got=%b exp=%b", i, {cap_req, cap_we, cap_be}, {2'b11, exp_be[i]}); end
      checks++; if (cap_wdata !== exp_w[i] || cap_addr !== exp_a[i]) begin failures++; $display("FAIL store_data_addr[%0d] got=%h/%h exp=%h/%h", i, cap_wdata, cap_addr, exp_w[i], exp_a[i]); end
      e = sb_q.pop_front();
      checks++; if ({wb_wreg_write, wb_wreg_addr, wb_wreg_data, wb_whilo, wb_hi, wb_lo} !== {e.wr, e.addr, e.data, e.whilo, e.hi, e.lo}) begin failures++; $display("FAIL store_wb[%0d] got=%h exp=%h", i, {wb_wreg_write, wb_wreg_addr, wb_wreg_data, wb_whilo, wb_hi, wb_lo}, {e.wr, e.addr, e.data, e.whilo, e.hi, e.lo}); end
    end
  endtask

  task automatic test_back_to_back();
    int stalls; bit done; wb_exp_t e;
    mem_op = LW; mem_addr = 32'h10; bus_rdata = 32'h11223344; mem_wreg_write = 1'b1; mem_wreg_addr = 5'd9;
    sb_q.push_back('{1'b1, 5'd9, 32'h11223344, 1'b0, 32'h0, 32'h0});
    run_access(0, stalls, done);
    checks++; if (!done || stalls != 1) begin failures++; $display("FAIL b2b_lw_stall got=%0d exp=1", stalls); end
    e = sb_q.pop_front();
    checks++; if ({wb_wreg_write, wb_wreg_addr, wb_wreg_data} !== {e.wr, e.addr, e.data}) begin failures++; $display("FAIL b2b_lw_wb got=%h exp=%h", {wb_wreg_write, wb_wreg_addr, wb_wreg_data}, {e.wr, e.addr, e.data}); end
    // ALU op right behind, with a stray ack that IDLE must ignore
    mem_wreg_write = 1'b1; mem_wreg_addr = 5'd17; mem_wreg_data = 32'hFEED_0001; bus_ack = 1'b1;
    sb_q.push_back('{1'b1, 5'd17, 32'hFEED_0001, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL b2b_alu_stall got=%b exp=0", stall_req); end
    next_cycle();
    e = sb_q.pop_front();
    checks++; if ({bus_req, wb_wreg_write, wb_wreg_addr, wb_wreg_data} !== {1'b0, e.wr, e.addr, e.data}) begin failures++; $display("FAIL b2b_alu_wb got=%h exp=%h", {bus_req, wb_wreg_write, wb_wreg_addr, wb_wreg_data}, {1'b0, e.wr, e.addr, e.data}); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_bus();
    mem_op = LW; mem_addr = 32'h40; mem_wreg_write = 1'b1; mem_wreg_addr = 5'd4; bus_rdata = 32'h600D_F00D;
    next_cycle();
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstbus_req_before got=%b exp=1", bus_req); end
    rst = 1'b0; #1;
    checks++; if ({bus_req, bus_be} !== 5'b0) begin failures++; $display("FAIL rstbus_async got=%b exp=0", {bus_req, bus_be}); end
    bus_ack = 1'b1; next_cycle(); next_cycle();
    idle_inputs(); bus_ack = 1'b1; rst = 1'b1;
    next_cycle(); bus_ack = 1'b0;
    checks++; if ({bus_req, wb_wreg_write} !== 2'b00) begin failures++; $display("FAIL rstbus_late_ack got=%b exp=00", {bus_req, wb_wreg_write}); end
    next_cycle();
  endtask

  task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
    mem_op = LW; mem_addr = 32'h102; mem_wreg_write = 1'b1; mem_wreg_addr = 5'd6; mem_whilo = 1'b1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", stall_req); end
    next_cycle(); idle_inputs();
    checks++; if ({bus_req, exc_addr_err, wb_wreg_write, wb_whilo} !== 4'b0100) begin failures++; $display("FAIL mis_exc got=%b exp=0100", {bus_req, exc_addr_err, wb_wreg_write, wb_whilo}); end
    checks++; if (exc_badvaddr !== 32'h102) begin failures++; $display("FAIL mis_badvaddr got=%h exp=102", exc_badvaddr); end
    next_cycle();
    checks++; if ({exc_addr_err, bus_req} !== 2'b00) begin failures++; $display("FAIL mis_pulse got=%b exp=00", {exc_addr_err, bus_req}); end
`else
    int stalls; bit done;
    mem_op = LW; mem_addr = 32'h102; bus_rdata = 32'h99887766; mem_wreg_write = 1'b1; mem_wreg_addr = 5'd6;
    run_access(0, stalls, done);
    checks++; if (!done || cap_addr !== 32'h100 || cap_be !== 4'b1111) begin failures++; $display("FAIL mis_access got=%h/%b exp=100/1111", cap_addr, cap_be); end
    checks++; if ({wb_wreg_write, wb_wreg_data} !== {1'b1, 32'h99887766}) begin failures++; $display("FAIL mis_wb got=%h exp=199887766", {wb_wreg_write, wb_wreg_data}); end
    checks++; if ({exc_addr_err, exc_badvaddr} !== 33'h0) begin failures++; $display("FAIL mis_exc got=%h exp=0", {exc_addr_err, exc_badvaddr}); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_loads();
    test_stores();
    test_back_to_back();
    test_reset_mid_bus();
    test_misaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
